// File: rtl/vc_route_demux_pkg.sv
// Shared constants and state encoding for the vc_route_demux consumer stage.
// Holds the route-field position, destination count and one-hot helper.
package vc_route_demux_pkg;

  localparam int NUM_DEST = 4;
  localparam int SEL_LSB  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ROUTE = 2'd2
  } state_e;

  function automatic logic [NUM_DEST-1:0] dest_onehot(input logic [1:0] sel);
    return NUM_DEST'(1) << sel;
  endfunction

endpackage

// File: rtl/vc_route_demux_if.sv
// Upstream FIFO read side, downstream push side and observability bus of vc_route_demux.
// master = the demux itself, slave = the surrounding FIFOs / bench.
interface vc_route_demux_if #(
  parameter int DATA_WIDTH = 10,
  parameter int CNT_WIDTH  = 8
);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_pop;
  logic [3:0]            almost_full_out;
  logic [3:0]            push_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  busy;
  logic [4*CNT_WIDTH-1:0] fwd_count;

  modport master (
    input  fifo_empty, fifo_data, almost_full_out,
    output fifo_pop, push_out, data_out, busy, fwd_count
  );

  modport slave (
    output fifo_empty, fifo_data, almost_full_out,
    input  fifo_pop, push_out, data_out, busy, fwd_count
  );

endinterface

// File: rtl/vc_route_demux_dest_counter_bank.sv
// Four wrapping per-destination forwarded-word counters; +1 on the edge after an inc bit.
// No backpressure: counts whatever push strobes it is given.
module vc_route_demux_dest_counter_bank
  import vc_route_demux_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_DEST-1:0]           inc,
  output logic [NUM_DEST*CNT_WIDTH-1:0] fwd_count
);

  logic [CNT_WIDTH-1:0] cnt_q [NUM_DEST];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_DEST];

  always_comb begin
    for (int i = 0; i < NUM_DEST; i++) begin
      cnt_d[i] = cnt_q[i] + CNT_WIDTH'(inc[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_DEST; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_DEST; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    fwd_count = '0;
    for (int i = 0; i < NUM_DEST; i++) begin
      fwd_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
    end
  end

endmodule

// File: rtl/vc_route_demux.sv
// Pops the upstream FIFO and pushes each word to the destination named by its route field.
// Pop-to-push latency 2 cycles, 1 word / 2 cycles; a full destination stalls the stage (head-of-line).
module vc_route_demux #(
  parameter int DATA_WIDTH = 10,
  parameter int SEL_LSB    = vc_route_demux_pkg::SEL_LSB,
  parameter int CNT_WIDTH  = 8
) (
  input logic               clk,
  input logic               reset,
  vc_route_demux_if.master  bus
);

  import vc_route_demux_pkg::*;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   hold_data_q, hold_data_d;
  logic [1:0]              dest;
  logic                    pop;
  logic [NUM_DEST-1:0]     push;
  logic [NUM_DEST*CNT_WIDTH-1:0] fwd_count;

  assign dest = hold_data_q[SEL_LSB+1:SEL_LSB];

  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    pop         = 1'b0;
    push        = '0;
    case (state_q)
      IDLE: begin
        if (!bus.fifo_empty) begin
          pop     = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        hold_data_d = bus.fifo_data;
        state_d     = ROUTE;
      end
      ROUTE: begin
        // Pop for the next word in the same cycle as the push to keep 1 word / 2 cycles.
        if (!bus.almost_full_out[dest]) begin
          push = dest_onehot(dest);
          if (!bus.fifo_empty) begin
            pop     = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      hold_data_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
    end
  end

  // Strobes are forced low while reset is held so no pop or push leaks out mid-reset.
  assign bus.fifo_pop  = pop & reset;
  assign bus.push_out  = push & {NUM_DEST{reset}};
  assign bus.data_out  = hold_data_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.fwd_count = fwd_count;

  vc_route_demux_dest_counter_bank #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_dest_counter_bank (
    .clk       (clk),
    .reset     (reset),
    .inc       (bus.push_out),
    .fwd_count (fwd_count)
  );

endmodule

// File: tb/tb_vc_route_demux.sv
// Bench for vc_route_demux: upstream FIFO model, in-order scoreboard and per-destination counts.
module tb_vc_route_demux;

  localparam int DW = 10;
  localparam int CW = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vc_route_demux_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  vc_route_demux #(.DATA_WIDTH(DW), .SEL_LSB(8), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_push = 0;

  logic [DW-1:0] up_q[$];   // words still in the upstream FIFO
  logic [DW-1:0] fly_q[$];  // words popped but not yet pushed, in order
  int            cnt_m[4];  // words delivered per destination, mod 256

  logic          s_pop, s_empty, s_busy;
  logic [3:0]    s_push, s_af;
  logic [DW-1:0] s_data;
  logic [4*CW-1:0] s_fwd;

  typedef struct {
    logic [DW-1:0] word;
    logic [3:0]    block;
    int            stall;
    logic [3:0]    exp_push;
    int            exp_lat;
    int            exp_cnt;
  } vec_t;
  vec_t vt[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4*CW-1:0] model_fwd();
    logic [4*CW-1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*CW +: CW] = CW'(cnt_m[i]);
    return r;
  endfunction

  task automatic load(input logic [DW-1:0] w);
    up_q.push_back(w);
    bus.fifo_empty = 1'b0;
  endtask

  // One clock cycle: called just after a falling edge with inputs already set.
  task automatic step();
    logic [DW-1:0] w;
    #2;
    s_pop   = bus.fifo_pop;
    s_push  = bus.push_out;
    s_data  = bus.data_out;
    s_busy  = bus.busy;
    s_fwd   = bus.fwd_count;
    s_empty = bus.fifo_empty;
    s_af    = bus.almost_full_out;
    check("fwd_count_track", s_fwd, model_fwd());
    if (s_pop) check("pop_while_empty", s_empty, 0);
    if (s_push != 4'b0) begin
      n_push++;
      if (fly_q.size() == 0) begin
        check("push_without_word", s_push, 0);
      end else begin
        w = fly_q.pop_front();
        check("push_data", s_data, w);
        check("push_dest", s_push, 4'b0001 << w[9:8]);
        check("push_into_full", s_push & s_af, 0);
        cnt_m[w[9:8]] = (cnt_m[w[9:8]] + 1) % 256;
      end
    end
    @(posedge clk);
    #1;
    if (s_pop && up_q.size() != 0) begin
      bus.fifo_data = up_q.pop_front();
      fly_q.push_back(bus.fifo_data);
    end
    bus.fifo_empty = (up_q.size() == 0);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    #1 reset = 1'b0;
    #1;
    check({tag, "_push"}, bus.push_out, 0);
    check({tag, "_pop"}, bus.fifo_pop, 0);
    check({tag, "_data"}, bus.data_out, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_fwd"}, bus.fwd_count, 0);
    fly_q.delete();
    cnt_m = '{default: 0};
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_until_idle(input int budget, input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(up_q.size() == 0 && fly_q.size() == 0 && !s_busy) && n < budget);
    check({name, "_drained"}, (up_q.size() == 0 && fly_q.size() == 0 && !s_busy), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pop_c, push_c, quiet, last_c, k, loaded, push0;
    logic [3:0] pushed;
    logic [DW-1:0] pdata;
    logic [3:0] exp_b[5];
    logic [DW-1:0] burst_w[5];
    logic want;
    logic [CW-1:0] wantv;

    bus.fifo_empty      = 1'b1;
    bus.fifo_data       = '0;
    bus.almost_full_out = 4'b0;
    cnt_m = '{default: 0};

    vt[0] = '{10'h201, 4'b0000, 0, 4'b0100, 2, 1};
    vt[1] = '{10'h1AA, 4'b0010, 5, 4'b0010, 7, 1};
    vt[2] = '{10'h0FF, 4'b0000, 0, 4'b0001, 2, 1};
    vt[3] = '{10'h3C3, 4'b1000, 3, 4'b1000, 5, 1};
    vt[4] = '{10'h155, 4'b0010, 1, 4'b0010, 3, 2};
    vt[5] = '{10'h2F0, 4'b0100, 2, 4'b0100, 4, 2};

    do_reset("reset");

    // Single words, optionally stalled by their own destination's almost_full.
    for (int i = 0; i < 6; i++) begin
      pop_c = -1; push_c = -1; quiet = 0; pushed = '0; pdata = '0;
      load(vt[i].word);
      for (int c = 0; c < 40 && push_c < 0; c++) begin
        bus.almost_full_out = (pop_c >= 0 && c - pop_c >= 2 + vt[i].stall) ? 4'b0 : vt[i].block;
        step();
        if (s_pop && pop_c < 0) pop_c = c;
        if (s_push != 4'b0) begin
          push_c = c; pushed = s_push; pdata = s_data;
        end else if (pop_c >= 0 && c - pop_c >= 2 && !s_pop && s_busy) begin
          quiet++;
        end
      end
      check($sformatf("vec%0d_pushed", i), push_c >= 0, 1);
      check($sformatf("vec%0d_lat", i), push_c - pop_c, vt[i].exp_lat);
      check($sformatf("vec%0d_push", i), pushed, vt[i].exp_push);
      check($sformatf("vec%0d_data", i), pdata, vt[i].word);
      check($sformatf("vec%0d_stall", i), quiet, vt[i].stall);
      bus.almost_full_out = 4'b0;
      step();
      check($sformatf("vec%0d_idle_busy", i), s_busy, 0);
      check($sformatf("vec%0d_idle_pop", i), s_pop, 0);
      check($sformatf("vec%0d_cnt", i), s_fwd[int'(vt[i].word[9:8])*CW +: CW], vt[i].exp_cnt);
    end

    // Burst across all destinations.
    do_reset("rst_burst");
    burst_w = '{10'h001, 10'h101, 10'h201, 10'h301, 10'h002};
    exp_b   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int j = 0; j < 5; j++) load(burst_w[j]);
    k = 0; last_c = 0;
    for (int c = 0; c < 40 && k < 5; c++) begin
      step();
      if (s_push != 4'b0) begin
        check($sformatf("burst%0d_dest", k), s_push, exp_b[k]);
        if (k > 0) check($sformatf("burst%0d_gap", k), c - last_c, 2);
        last_c = c;
        k++;
      end
    end
    check("burst_pushes", k, 5);
    run_until_idle(20, "burst");
    check("burst_counts", s_fwd, 32'h01010102);

    // Empty upstream: nothing moves.
    for (int c = 0; c < 10; c++) begin
      step();
      check($sformatf("empty%0d_quiet", c), {s_pop, s_push, s_busy}, 0);
    end

    // Reset while stalled; the held word is lost and the next word flows normally.
    load(10'h2AB);
    load(10'h0C5);
    bus.almost_full_out = 4'b0100;
    for (int c = 0; c < 6; c++) step();
    check("stall_busy", s_busy, 1);
    check("stall_push", s_push, 0);
    check("stall_pop", s_pop, 0);
    do_reset("rst_stall");
    bus.almost_full_out = 4'b0;
    pop_c = -1; push_c = -1; pdata = '0; pushed = '0;
    for (int c = 0; c < 20 && push_c < 0; c++) begin
      step();
      if (s_pop && pop_c < 0) pop_c = c;
      if (s_push != 4'b0) begin
        push_c = c; pushed = s_push; pdata = s_data;
      end
    end
    check("post_rst_data", pdata, 10'h0C5);
    check("post_rst_push", pushed, 4'b0001);
    check("post_rst_lat", push_c - pop_c, 2);
    run_until_idle(20, "post_rst");
    check("post_rst_cnt", s_fwd, 32'h00000001);

    // Counter wrap on destination 3.
    do_reset("rst_wrap");
    for (int j = 0; j < 256; j++) load(DW'(10'h300 | j));
    k = 0; want = 1'b0; wantv = '0;
    for (int n = 0; n < 1200; n++) begin
      step();
      if (want) begin
        check($sformatf("wrap_cnt_after_%0d", k), s_fwd[3*CW +: CW], wantv);
        want = 1'b0;
      end
      if (s_push != 4'b0) begin
        k++;
        if (k == 255) begin want = 1'b1; wantv = 8'd255; end
        if (k == 256) begin want = 1'b1; wantv = 8'd0; end
      end
      if (k == 256 && !want) break;
    end
    check("wrap_pushes", k, 256);

    // Random traffic and random backpressure against the scoreboard.
    do_reset("rst_rand");
    loaded = 0;
    push0  = n_push;
    for (int c = 0; c < 700; c++) begin
      if (loaded < 200 && up_q.size() < 8 && $urandom_range(2) == 0) begin
        load(DW'($urandom));
        loaded++;
      end
      bus.almost_full_out = 4'($urandom & $urandom);
      step();
    end
    bus.almost_full_out = 4'b0;
    run_until_idle(100, "rand");
    check("rand_total", n_push - push0, loaded);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
